k2_program_loader: RTL and testbench
====================================

K2_PROGRAM_LOADER -- requirements
Module: k2_program_loader

Interface
REQ-001 Parameter BITS, default 8: instruction/data byte width.
REQ-002 Parameter DEPTH, default 16: program words, addressed by a 4-bit program address.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 start  input  1  one-cycle request to begin a program load.
REQ-006 in_valid  input  1  in_data holds a valid program byte.
REQ-007 in_data  input  BITS  program byte stream, address order 0..DEPTH-1.
REQ-008 in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid && in_ready.
REQ-009 prog_addr  input  4  processor ProgramAddress.
REQ-010 instruction_data  output  BITS  program word at prog_addr, fed to the processor.
REQ-011 pc_en  output  1  processor PC enable; high only in RUN.
REQ-012 proc_rst  output  1  processor hold-in-reset; high in every state except RUN.
REQ-013 load_count  output  5  bytes accepted in the current load, 0..DEPTH.
REQ-014 error  output  1  checksum failure flag; present only when the checksum feature is compiled in.

Function
REQ-015 FSM states: IDLE, LOAD, CHECK (feature only), RUN, ERROR (feature only); outputs decode from the registered state with no added latency.
REQ-016 IDLE: in_ready=0; start=1 -> LOAD next cycle, write pointer and load_count cleared to 0.
REQ-017 LOAD: in_ready=1; each transfer writes mem[wptr]<=in_data, increments wptr and load_count.
REQ-018 Transfer of byte DEPTH-1 -> RUN on the next edge (CHECK with the feature); wptr wraps to 0 and no further byte is written.
REQ-019 start in LOAD or CHECK is ignored; start in RUN or ERROR -> LOAD (reload), with pc_en falling and proc_rst rising in that same cycle.
REQ-020 in_valid without in_ready (IDLE, RUN, ERROR) is ignored and writes nothing.
REQ-021 Simultaneous start and in_valid in IDLE: the state moves to LOAD and the byte is not accepted.
REQ-022 instruction_data = mem[prog_addr] as a combinational read, valid in every state; bytes written in cycle N are readable from cycle N+1.
REQ-023 Absence of in_valid in LOAD stalls indefinitely with no timeout.
REQ-024 load_count holds at DEPTH in RUN until the next load begins.

Reset
REQ-025 rst=1 at any edge, including mid-load: state=IDLE, wptr=0, load_count=0, checksum accumulator=0, error=0, all memory words=0.
REQ-026 Outputs during and after reset: in_ready=0, pc_en=0, proc_rst=1, instruction_data=0.

Configuration
REQ-027 The macro K2_LOADER_CHECKSUM_EN compiles in a trailing checksum byte.
REQ-028 With the macro: the accumulator sums the DEPTH bytes modulo 2^BITS; CHECK holds in_ready=1 and accepts one byte; equal -> RUN, unequal -> ERROR (error=1, pc_en=0); error clears on start or rst.
REQ-029 Without the macro: the CHECK and ERROR states, the accumulator and the error port are absent; LOAD goes directly to RUN.

Structure
REQ-030 Shared package k2_pkg holds the state enum, the default BITS/DEPTH constants and the program-address width localparam.
REQ-031 Storage is the single sub-module k2_prog_ram, with a 1-write synchronous port, a combinational read port and synchronous clear; all FSM and counter logic lives in the top module.

Verification
REQ-032 Reset, start, stream bytes 0x10..0x1F back-to-back -> in_ready high 16 cycles; RUN on the next edge; prog_addr=5 gives 0x15; pc_en=1, proc_rst=0; load_count=16.
REQ-033 In LOAD, deassert in_valid for 3 cycles after byte 7 -> load_count holds at 8 and no write occurs; load completes with the correct contents.
REQ-034 rst at byte 9 of a load -> IDLE, all words read 0x00, load_count=0; a fresh load of 0xA0..0xAF then succeeds.
REQ-035 In RUN, assert start -> pc_en=0 and proc_rst=1 that cycle; a reload of 0xFF x16 makes prog_addr=0 read 0xFF.
REQ-036 With K2_LOADER_CHECKSUM_EN: bytes 0x01 x16 followed by checksum 0x10 -> RUN; same bytes with checksum 0x11 -> ERROR, error=1, pc_en=0; then start -> LOAD and error=0.
REQ-037 start and in_valid asserted together in IDLE with in_data=0x55 -> the byte is not written; the next byte, 0x66, lands at address 0.

Source files
------------

// File: rtl/k2_pkg.sv
// k2 program loader shared types and constants.
// State encoding, default widths and program-address width.
package k2_pkg;

  localparam int K2_BITS  = 8;
  localparam int K2_DEPTH = 16;
  localparam int K2_AW    = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/k2_prog_ram.sv
// k2 program store: one synchronous write port,
// combinational read port, synchronous clear.
module k2_prog_ram
  import k2_pkg::*;
#(
  parameter int BITS  = K2_BITS,
  parameter int DEPTH = K2_DEPTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [K2_AW-1:0] waddr,
  input  logic [BITS-1:0]  wdata,
  input  logic [K2_AW-1:0] raddr,
  output logic [BITS-1:0]  rdata
);

  logic [BITS-1:0] mem [DEPTH];

  // clear wins over a write in the same cycle
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/k2_program_loader.sv
// k2 program loader: streams DEPTH bytes into program RAM, then runs.
// Define K2_LOADER_CHECKSUM_EN for a trailing checksum byte and error port.
module k2_program_loader
  import k2_pkg::*;
#(
  parameter int BITS  = K2_BITS,
  parameter int DEPTH = K2_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [BITS-1:0]  in_data,
  output logic             in_ready,
  input  logic [K2_AW-1:0] prog_addr,
  output logic [BITS-1:0]  instruction_data,
  output logic             pc_en,
  output logic             proc_rst,
`ifdef K2_LOADER_CHECKSUM_EN
  output logic             error,
`endif
  output logic [4:0]       load_count
);

  state_t           state_q;
  logic [K2_AW-1:0] wptr_q;
  logic [4:0]       cnt_q;
  logic             is_load;
  logic             is_check;
  logic             is_run;
  logic             xfer;
  logic             last;
  logic             we;
  logic [BITS-1:0]  rdata;

`ifdef K2_LOADER_CHECKSUM_EN
  logic [BITS-1:0]  acc_q;
  logic             err_q;
  assign is_check = (state_q == S_CHECK);
  assign error    = err_q;
`else
  assign is_check = 1'b0;
`endif

  assign is_load  = (state_q == S_LOAD);
  assign is_run   = (state_q == S_RUN);
  assign in_ready = !rst && (is_load || is_check);
  assign xfer     = in_valid && in_ready;
  assign last     = (wptr_q == K2_AW'(DEPTH - 1));
  assign we       = xfer && is_load;

  // a restart request drops the core out of RUN in the same cycle
  assign pc_en    = !rst && is_run && !start;
  assign proc_rst = !pc_en;

  assign instruction_data = rst ? '0 : rdata;
  assign load_count       = cnt_q;

  // loader FSM, write pointer, byte count and checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
`ifdef K2_LOADER_CHECKSUM_EN
      acc_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          if (start) begin
            state_q <= S_LOAD;
            wptr_q  <= '0;
            cnt_q   <= '0;
`ifdef K2_LOADER_CHECKSUM_EN
            acc_q   <= '0;
`endif
          end
        end
        (state_q == S_LOAD): begin
          if (xfer) begin
            wptr_q <= last ? '0 : wptr_q + 1'b1;
            cnt_q  <= cnt_q + 5'd1;
`ifdef K2_LOADER_CHECKSUM_EN
            acc_q  <= acc_q + in_data;
            if (last) state_q <= S_CHECK;
`else
            if (last) state_q <= S_RUN;
`endif
          end
        end
`ifdef K2_LOADER_CHECKSUM_EN
        (state_q == S_CHECK): begin
          if (xfer) begin
            if (acc_q == in_data) begin
              state_q <= S_RUN;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end
          end
        end
        (state_q == S_ERROR): begin
          if (start) begin
            state_q <= S_LOAD;
            wptr_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
          end
        end
`endif
        (state_q == S_RUN): begin
          if (start) begin
            state_q <= S_LOAD;
            wptr_q  <= '0;
            cnt_q   <= '0;
`ifdef K2_LOADER_CHECKSUM_EN
            acc_q   <= '0;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  k2_prog_ram #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .clr   (rst),
    .we    (we),
    .waddr (wptr_q),
    .wdata (in_data),
    .raddr (prog_addr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_k2_program_loader.sv
// Self-checking bench for k2_program_loader.
// Vector table plus directed multi-cycle sequences.
module tb_k2_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] prog_addr;
  logic [7:0] instruction_data;
  logic       pc_en;
  logic       proc_rst;
  logic [4:0] load_count;
`ifdef K2_LOADER_CHECKSUM_EN
  logic       error;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  k2_program_loader dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .prog_addr        (prog_addr),
    .instruction_data (instruction_data),
    .pc_en            (pc_en),
    .proc_rst         (proc_rst),
`ifdef K2_LOADER_CHECKSUM_EN
    .error            (error),
`endif
    .load_count       (load_count)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic [3:0] addr;
    logic       e_ready;
    logic       e_pc;
    logic       e_prst;
    logic [4:0] e_cnt;
    logic [7:0] e_idata;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    chk("send_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load16(input logic [7:0] base, input logic [7:0] step);
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      send(base + 8'(i) * step);
    end
  endtask

  task automatic check_mem(input string nm, input logic [7:0] base,
                           input logic [7:0] step);
    for (int a = 0; a < 16; a++) begin
      prog_addr = 4'(a);
      #1;
      chk($sformatf("%s_a%0d", nm, a), instruction_data,
          base + 8'(a) * step);
    end
  endtask

  task automatic check_run(input string nm);
    #1;
    chk({nm, "_ready"}, in_ready, 1'b0);
    chk({nm, "_pc"}, pc_en, 1'b1);
    chk({nm, "_prst"}, proc_rst, 1'b0);
    chk({nm, "_cnt"}, load_count, 5'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_data = 8'h00; prog_addr = 4'd0;

    vt[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00};
    vt[1] = '{1'b0, 1'b0, 1'b1, 8'h77, 4'd0, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00};
    vt[2] = '{1'b0, 1'b1, 1'b1, 8'h55, 4'd0, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00};
    vt[3] = '{1'b0, 1'b0, 1'b1, 8'h66, 4'd0, 1'b1, 1'b0, 1'b1, 5'd0, 8'h00};
    vt[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1, 5'd1, 8'h66};
    vt[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1, 1'b0, 1'b1, 5'd1, 8'h00};
    vt[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1, 5'd1, 8'h66};
    vt[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1, 5'd1, 8'h66};
    vt[8] = '{1'b1, 1'b0, 1'b1, 8'h99, 4'd0, 1'b0, 1'b0, 1'b1, 5'd1, 8'h00};
    vt[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00};

    tick();
    for (int i = 0; i < 10; i++) begin
      rst       = vt[i].rst;
      start     = vt[i].start;
      in_valid  = vt[i].valid;
      in_data   = vt[i].data;
      prog_addr = vt[i].addr;
      #1;
      chk($sformatf("v%0d_ready", i), in_ready, vt[i].e_ready);
      chk($sformatf("v%0d_pc", i), pc_en, vt[i].e_pc);
      chk($sformatf("v%0d_prst", i), proc_rst, vt[i].e_prst);
      chk($sformatf("v%0d_cnt", i), load_count, vt[i].e_cnt);
      chk($sformatf("v%0d_idata", i), instruction_data, vt[i].e_idata);
      tick();
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;

    do_reset();
    load16(8'h10, 8'h01);
    check_run("basic");
    prog_addr = 4'd5;
    #1;
    chk("basic_a5", instruction_data, 8'h15);
    check_mem("basic", 8'h10, 8'h01);

    start = 1'b1;
    #1;
    chk("restart_pc", pc_en, 1'b0);
    chk("restart_prst", proc_rst, 1'b1);
    tick();
    start = 1'b0;
    #1;
    chk("restart_cnt", load_count, 5'd0);
    chk("restart_ready", in_ready, 1'b1);
    for (int i = 0; i < 16; i++) send(8'hFF);
    check_run("reload");
    prog_addr = 4'd0;
    #1;
    chk("reload_a0", instruction_data, 8'hFF);
    check_mem("reload", 8'hFF, 8'h00);

    do_reset();
    pulse_start();
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
    in_data = 8'hEE;
    prog_addr = 4'd8;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_cnt", k), load_count, 5'd8);
      chk($sformatf("stall%0d_ready", k), in_ready, 1'b1);
      chk($sformatf("stall%0d_a8", k), instruction_data, 8'h00);
      tick();
    end
    for (int i = 8; i < 16; i++) send(8'h20 + 8'(i));
    check_run("stall");
    check_mem("stall", 8'h20, 8'h01);

    do_reset();
    pulse_start();
    for (int i = 0; i < 9; i++) send(8'h30 + 8'(i));
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h39;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_cnt", load_count, 5'd0);
    chk("midrst_ready", in_ready, 1'b0);
    chk("midrst_prst", proc_rst, 1'b1);
    check_mem("midrst", 8'h00, 8'h00);
    load16(8'hA0, 8'h01);
    check_run("fresh");
    check_mem("fresh", 8'hA0, 8'h01);

`ifdef K2_LOADER_CHECKSUM_EN
    do_reset();
    load16(8'h01, 8'h00);
    #1;
    chk("ck_check_ready", in_ready, 1'b1);
    chk("ck_check_pc", pc_en, 1'b0);
    chk("ck_check_cnt", load_count, 5'd16);
    send(8'h10);
    check_run("ck_good");
    chk("ck_good_err", error, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) send(8'h01);
    send(8'h11);
    #1;
    chk("ck_bad_err", error, 1'b1);
    chk("ck_bad_pc", pc_en, 1'b0);
    chk("ck_bad_prst", proc_rst, 1'b1);
    chk("ck_bad_ready", in_ready, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("ck_clr_err", error, 1'b0);
    chk("ck_clr_ready", in_ready, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
